// File: rtl/lcd_sequencer.sv
// Byte sequencer for an HD44780-style LCD controller: plays the fixed startup list,
// then drains a command/character FIFO one byte at a time with a settle wait after clear/home.
module lcd_sequencer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int LONG_WAIT_NS = 1640000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_clk_ns,
    input  logic       wr_en,
    input  logic       wr_is_cmd,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic [6:0] fifo_count,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs_out,
    output logic [7:0] lcd_data_out,
    output logic       lcd_strobe_out,
    input  logic       lcd_done_in
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT_LOAD, S_ISSUE, S_WAIT_DONE, S_LONG_WAIT, S_IDLE, S_POP
    } state_t;

    state_t        state, state_nxt, after_byte;
    logic [1:0]    init_idx;
    logic          init_done_q;
    logic          strobe_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic [23:0]   wait_cnt, wait_sum;
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [8:0]    fifo_head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [6:0]    count;
    logic [7:0]    init_byte;
    logic          push, pop, long_cmd, wait_hit, byte_done;

    always_comb begin
        case (init_idx)
            2'd0:    init_byte = 8'h28;
            2'd1:    init_byte = 8'h06;
            2'd2:    init_byte = 8'h0C;
            default: init_byte = 8'h01;
        endcase
    end

    assign push      = wr_en && (count < 7'(FIFO_DEPTH));
    assign pop       = (state == S_POP);
    assign fifo_head = fifo_mem[rd_ptr];
    // Clear (0x01) and home (0x02/0x03) need the long settle before the next byte.
    assign long_cmd  = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
    assign wait_sum  = wait_cnt + {16'd0, period_clk_ns};
    assign wait_hit  = (wait_sum >= 24'(LONG_WAIT_NS));
    assign byte_done = (state == S_WAIT_DONE && lcd_done_in && !long_cmd) ||
                       (state == S_LONG_WAIT && wait_hit);
    assign after_byte = (!init_done_q && init_idx != 2'd3) ? S_INIT_LOAD : S_IDLE;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT_LOAD;
        else      state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT_LOAD: state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (lcd_done_in) state_nxt = long_cmd ? S_LONG_WAIT : after_byte;
            S_LONG_WAIT: if (wait_hit) state_nxt = after_byte;
            S_IDLE:      if (count != 7'd0) state_nxt = S_POP;
            S_POP:       state_nxt = S_ISSUE;
            default:     state_nxt = S_INIT_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_idx    <= 2'd0;
            init_done_q <= 1'b0;
            strobe_q    <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            wait_cnt    <= 24'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 7'd0;
        end else begin
            case (state)
                S_INIT_LOAD: begin
                    rs_q   <= 1'b0;
                    data_q <= init_byte;
                end
                S_ISSUE:     strobe_q <= 1'b1;
                S_WAIT_DONE: if (lcd_done_in) strobe_q <= 1'b0;
                S_LONG_WAIT: wait_cnt <= wait_hit ? 24'd0 : wait_sum;
                S_POP: begin
                    rs_q   <= ~fifo_head[8];
                    data_q <= fifo_head[7:0];
                end
                default: ;
            endcase

            if (byte_done && !init_done_q) begin
                if (init_idx == 2'd3) init_done_q <= 1'b1;
                else                  init_idx    <= init_idx + 2'd1;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {wr_is_cmd, wr_data};
    end

    always_comb begin
        lcd_strobe_out = strobe_q & ~lcd_done_in;
        busy           = (state != S_IDLE) || (count != 7'd0);
        fifo_full      = (count == 7'(FIFO_DEPTH));
        fifo_count     = count;
        init_done      = init_done_q;
        lcd_rs_out     = rs_q;
        lcd_data_out   = data_q;
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer: bench-driven controller model answering each strobe
// with a done pulse 50 cycles later; expectations are hand-computed per step.
module tb_lcd_sequencer;

    localparam int DONE_LAT = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] period_clk_ns = 8'd255;
    logic       wr_en = 1'b0;
    logic       wr_is_cmd = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full;
    logic [6:0] fifo_count;
    logic       busy;
    logic       init_done;
    logic       lcd_rs_out;
    logic [7:0] lcd_data_out;
    logic       lcd_strobe_out;
    logic       lcd_done_in = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] ent [17];

    lcd_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .period_clk_ns  (period_clk_ns),
        .wr_en          (wr_en),
        .wr_is_cmd      (wr_is_cmd),
        .wr_data        (wr_data),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .init_done      (init_done),
        .lcd_rs_out     (lcd_rs_out),
        .lcd_data_out   (lcd_data_out),
        .lcd_strobe_out (lcd_strobe_out),
        .lcd_done_in    (lcd_done_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic is_cmd, input logic [7:0] d);
        wr_en = 1'b1;
        wr_is_cmd = is_cmd;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Gap counts negedges from the current one until strobe is seen; -1 skips the gap check.
    task automatic wait_strobe(input string tag, input int exp_gap, input int budget);
        int gap = 0;
        while (lcd_strobe_out !== 1'b1 && gap < budget) begin
            @(negedge clk);
            gap++;
        end
        check({tag, "_seen"}, 32'(lcd_strobe_out), 32'd1);
        if (exp_gap >= 0) check({tag, "_gap"}, gap, exp_gap);
    endtask

    task automatic serve(input string tag, input logic exp_rs, input logic [7:0] exp_data);
        check({tag, "_rs"}, 32'(lcd_rs_out), 32'(exp_rs));
        check({tag, "_data"}, 32'(lcd_data_out), 32'(exp_data));
        repeat (DONE_LAT - 1) @(negedge clk);
        lcd_done_in = 1'b1;
        #1;
        check({tag, "_mask"}, 32'(lcd_strobe_out), 32'd0);
        check({tag, "_hold"}, {23'd0, lcd_rs_out, lcd_data_out}, {23'd0, exp_rs, exp_data});
        @(negedge clk);
        lcd_done_in = 1'b0;
    endtask

    task automatic serve_startup(input int first_gap);
        wait_strobe("init0", first_gap, 10); serve("init0", 1'b0, 8'h28);
        wait_strobe("init1", 2, 10);         serve("init1", 1'b0, 8'h06);
        wait_strobe("init2", 2, 10);         serve("init2", 1'b0, 8'h0C);
        wait_strobe("init3", 2, 10);         serve("init3", 1'b0, 8'h01);
    endtask

    task automatic wait_init_done(input int exp_cycles, input int budget);
        int k = 0;
        while (init_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("init_done_set", 32'(init_done), 32'd1);
        check("init_long_wait", k, exp_cycles);
    endtask

    initial begin
        logic seen;
        ent[0] = {1'b1, 8'h02};
        ent[1] = {1'b1, 8'h80};
        for (int i = 2; i < 16; i++) ent[i] = {1'b0, 8'h50 + 8'(i)};
        ent[16] = {1'b0, 8'hEE};

        // Reset state (period 255 for this phase)
        #12;
        check("rst_rs", 32'(lcd_rs_out), 32'd0);
        check("rst_data", 32'(lcd_data_out), 32'h00);
        check("rst_strobe", 32'(lcd_strobe_out), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Fill the FIFO while the startup byte is stalled waiting for done
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_entry(ent[i][8], ent[i][7:0]);
            check($sformatf("fill_count%0d", i), 32'(fifo_count), (i < 16) ? i + 1 : 16);
        end
        check("fill_full", 32'(fifo_full), 32'd1);

        // ceil(1640000/255) = 6432 settle cycles after clear
        serve_startup(-1);
        wait_init_done(6432, 7000);
        check("count_after_init", 32'(fifo_count), 32'd16);

        // 0x02 needs the long wait; 0x80 does not
        wait_strobe("e0", 3, 10);
        serve("e0", 1'b0, 8'h02);
        wait_strobe("e1", 6435, 7000);
        serve("e1", 1'b0, 8'h80);
        for (int i = 2; i <= 10; i++) begin
            wait_strobe($sformatf("e%0d", i), 3, 10);
            serve($sformatf("e%0d", i), ~ent[i][8], ent[i][7:0]);
        end

        // Push lands on the same edge as the pop of e11, with count at 5
        @(negedge clk);
        check("pp_count_before", 32'(fifo_count), 32'd5);
        push_entry(1'b0, 8'h7A);
        check("pp_count_after", 32'(fifo_count), 32'd5);
        wait_strobe("e11", 1, 10);
        serve("e11", 1'b1, ent[11][7:0]);
        for (int i = 12; i < 16; i++) begin
            wait_strobe($sformatf("e%0d", i), 3, 10);
            serve($sformatf("e%0d", i), 1'b1, ent[i][7:0]);
        end
        wait_strobe("pp_new", 3, 10);
        serve("pp_new", 1'b1, 8'h7A);
        check("drained_count", 32'(fifo_count), 32'd0);
        check("drained_busy", 32'(busy), 32'd0);

        // Stray done while idle must be ignored
        lcd_done_in = 1'b1;
        @(negedge clk);
        lcd_done_in = 1'b0;
        @(negedge clk);
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_strobe", 32'(lcd_strobe_out), 32'd0);

        // Single character from idle, then no reissue
        push_entry(1'b0, 8'h41);
        wait_strobe("char41", 3, 10);
        serve("char41", 1'b1, 8'h41);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_strobe_out === 1'b1) seen = 1'b1;
        end
        check("char41_no_reissue", 32'(seen), 32'd0);
        check("char41_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a transfer with entries queued
        push_entry(1'b0, 8'h55);
        push_entry(1'b0, 8'h56);
        push_entry(1'b0, 8'h57);
        wait_strobe("pre_rst", 1, 10);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_strobe", 32'(lcd_strobe_out), 32'd0);
        check("arst_rs", 32'(lcd_rs_out), 32'd0);
        check("arst_data", 32'(lcd_data_out), 32'h00);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_full", 32'(fifo_full), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_init_done", 32'(init_done), 32'd0);

        // Restart at period 20: 1640000/20 = 82000 settle cycles
        period_clk_ns = 8'd20;
        @(negedge clk);
        rst = 1'b1;
        serve_startup(2);
        wait_init_done(82000, 90000);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (lcd_strobe_out === 1'b1) seen = 1'b1;
        end
        check("post_rst_fifo_empty", 32'(fifo_count), 32'd0);
        check("post_rst_no_strobe", 32'(seen), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, 16, entries in the command/character FIFO; power of two, 2..64.
REQ-002 Parameter LONG_WAIT_NS, 1640000, extra settle time after clear/home commands, ns.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 period_clk_ns  input  8  clock period in ns, static after reset.
REQ-006 wr_en  input  1  push {wr_is_cmd, wr_data} into the FIFO this cycle.
REQ-007 wr_is_cmd  input  1  1 = LCD instruction (RS=0), 0 = character (RS=1).
REQ-008 wr_data  input  8  instruction or character byte.
REQ-009 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 fifo_count  output  7  current FIFO occupancy.
REQ-011 busy  output  1  sequencer not in S_IDLE, or FIFO non-empty.
REQ-012 init_done  output  1  startup command list completed.
REQ-013 lcd_rs_out  output  1  drives lcd_controller rs_in.
REQ-014 lcd_data_out  output  8  drives lcd_controller data_in.
REQ-015 lcd_strobe_out  output  1  drives lcd_controller strobe_in.
REQ-016 lcd_done_in  input  1  lcd_controller done pulse.

Function
REQ-017 FSM states: S_INIT_LOAD, S_ISSUE, S_WAIT_DONE, S_LONG_WAIT, S_IDLE, S_POP.
REQ-018 Startup list, fixed order, all RS=0: 0x28 (4-bit, 2 lines), 0x06 (entry mode), 0x0C (display on), 0x01 (clear); 2-bit index.
REQ-019 S_INIT_LOAD: load list[index] into rs/data registers -> S_ISSUE.
REQ-020 S_ISSUE: set strobe_q=1 -> S_WAIT_DONE.
REQ-021 lcd_strobe_out SHALL equal strobe_q AND NOT lcd_done_in (combinational mask), so the controller never samples strobe high in the cycle done is asserted.
REQ-022 S_WAIT_DONE: lcd_rs_out/lcd_data_out held stable; on lcd_done_in=1 clear strobe_q; if byte was a command equal to 0x01, 0x02 or 0x03 -> S_LONG_WAIT, else next state per REQ-024.
REQ-023 S_LONG_WAIT: 24-bit counter accumulates period_clk_ns each cycle; when counter >= LONG_WAIT_NS, clear counter, go to next state per REQ-024.
REQ-024 Next state: during startup, index<3 -> increment, S_INIT_LOAD; index==3 -> set init_done, S_IDLE; after startup -> S_IDLE.
REQ-025 S_IDLE: FIFO non-empty -> S_POP; else stay.
REQ-026 S_POP: read FIFO head into rs/data registers (rs = NOT is_cmd), decrement occupancy -> S_ISSUE; head-to-strobe latency exactly 2 cycles from S_IDLE.
REQ-027 FIFO: 9-bit entries, wrapping read/write pointers, count register; push accepted only when wr_en=1 and count<FIFO_DEPTH; push while full silently dropped, no state change.
REQ-028 Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
REQ-029 Pushes accepted during startup; entries issued only after init_done.
REQ-030 lcd_done_in while not in S_WAIT_DONE SHALL be ignored.
REQ-031 Only one byte is outstanding at the controller at any time; no new strobe until the previous done plus any long wait.

Reset
REQ-032 rst=0 asynchronously: state S_INIT_LOAD, index 0, strobe_q 0, counter 0, FIFO pointers/count 0, init_done 0, lcd_rs_out 0, lcd_data_out 0x00, fifo_full 0, busy 1.
REQ-033 Reset mid-transfer abandons the byte and the FIFO contents; startup list restarts from 0x28 after release.
REQ-034 Reset release synchronised by design constraint only; first active edge after rst=1 executes S_INIT_LOAD.

Verification
REQ-035 Reset release, controller model returning done 50 cycles after each strobe, period 20 -> strobes carry 0x28,0x06,0x0C,0x01 RS=0; 82000 cycles gap after 0x01 done; then init_done=1.
REQ-036 After init, push char 0x41 -> lcd_rs_out=1, lcd_data_out=0x41, strobe high 2 cycles after S_IDLE, strobe masked low in the done cycle, no reissue.
REQ-037 Push 17 entries with FIFO_DEPTH=16 while stalled in startup -> fifo_full=1 after 16, 17th dropped, exactly 16 bytes later issued in push order.
REQ-038 Push command 0x02 -> long wait of ceil(1640000/period) cycles before next strobe; command 0x80 -> next strobe immediately after done.
REQ-039 Simultaneous push and pop with count=5 -> count stays 5, data order preserved.
REQ-040 Assert rst=0 while in S_WAIT_DONE -> all outputs to REQ-032 values same cycle, FIFO empty, startup resumes from 0x28.
